// File: rtl/cu_dispatch_arbiter.sv
// cu_dispatch_arbiter: round-robin dispatch of instructions to two compute units,
// with strictly in-order result return and a per-unit busy watchdog.
module cu_dispatch_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr_data,
  output logic        instr_ready,
  output logic [1:0]  cu_start,
  output logic [15:0] cu_instr,
  input  logic [1:0]  cu_done,
  input  logic [7:0]  cu_result0,
  input  logic [7:0]  cu_result1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_unit,
  output logic [3:0]  res_tag,
  output logic        err_timeout,
  output logic        err_spurious
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} unit_state_t;

  unit_state_t state [2];
  logic [7:0]  hold [2];
  logic [7:0]  busy_cnt [2];
  logic [7:0]  result_in [2];
  logic        rr_ptr;
  logic [3:0]  seq_cnt;
  logic        fifo_unit [2];
  logic [3:0]  fifo_tag [2];
  logic        fifo_rd;
  logic        fifo_wr;
  logic [1:0]  fifo_cnt;
  logic        dispatch;
  logic        pick;
  logic        retire;
  logic        head_unit;

  assign result_in[0] = cu_result0;
  assign result_in[1] = cu_result1;

  // A unit only becomes dispatchable after the edge that retires it, since
  // readiness looks at registered state alone.
  assign instr_ready = (state[0] == IDLE) || (state[1] == IDLE);
  assign dispatch    = instr_valid && instr_ready;
  assign pick        = (state[0] == IDLE && state[1] == IDLE) ? rr_ptr : (state[0] != IDLE);

  assign head_unit = fifo_unit[fifo_rd];
  assign res_valid = (fifo_cnt != 2'd0) && (state[head_unit] == DONE);
  assign res_data  = hold[head_unit];
  assign res_unit  = head_unit;
  assign res_tag   = fifo_tag[fifo_rd];
  assign retire    = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= 1'b0;
      seq_cnt      <= 4'd0;
      fifo_rd      <= 1'b0;
      fifo_wr      <= 1'b0;
      fifo_cnt     <= 2'd0;
      cu_start     <= 2'b00;
      cu_instr     <= 16'h0000;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state[i]     <= IDLE;
        hold[i]      <= 8'h00;
        busy_cnt[i]  <= 8'h00;
        fifo_unit[i] <= 1'b0;
        fifo_tag[i]  <= 4'd0;
      end
    end else begin
      cu_start <= 2'b00;
      if (dispatch) begin
        cu_start[pick]     <= 1'b1;
        cu_instr           <= instr_data;
        rr_ptr             <= ~pick;
        seq_cnt            <= seq_cnt + 4'd1;
        fifo_unit[fifo_wr] <= pick;
        fifo_tag[fifo_wr]  <= seq_cnt;
        fifo_wr            <= ~fifo_wr;
      end
      if (retire) begin
        fifo_rd <= ~fifo_rd;
      end
      case ({dispatch, retire})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: ;
      endcase

      // A real completion wins over a watchdog expiry landing on the same edge.
      for (int i = 0; i < 2; i++) begin
        case (state[i])
          IDLE: begin
            if (cu_done[i]) err_spurious <= 1'b1;
            if (dispatch && pick == 1'(i)) begin
              state[i]    <= BUSY;
              busy_cnt[i] <= 8'h00;
            end
          end
          BUSY: begin
            if (cu_done[i]) begin
              hold[i]  <= result_in[i];
              state[i] <= DONE;
            end else if (busy_cnt[i] == 8'(TIMEOUT - 1)) begin
              hold[i]     <= 8'hFF;
              state[i]    <= DONE;
              err_timeout <= 1'b1;
            end else begin
              busy_cnt[i] <= busy_cnt[i] + 8'd1;
            end
          end
          DONE: begin
            if (cu_done[i]) err_spurious <= 1'b1;
            if (retire && head_unit == 1'(i)) state[i] <= IDLE;
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

endmodule
